vga_cmd_fifo: RTL and testbench

Command queue between the CPU bus and the `vga` command port. The CPU writes 32-bit graphics commands into a memory-mapped data register. The block buffers them in a FIFO and presents them as an AXI-stream master that connects directly to `cmd_axis_*` of `vga`. A status register exposes fill level, full/empty and a sticky overflow flag, so software can throttle without stalling the bus.

---
 rtl/vga_cmd_fifo.sv | 81 ++++++++
 tb/tb_vga_cmd_fifo.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_cmd_fifo.sv
// vga_cmd_fifo: CPU-written command queue feeding the vga AXI-stream command port.
// Define VGA_CMD_FIFO_DROPS_EN to build the saturating drop counter at address 2.
module vga_cmd_fifo #(
   parameter int DEPTH = 16,
   parameter int LW    = $clog2(DEPTH) + 1
) (
   input  logic        clk,
   input  logic        reset_n_i,
   input  logic        sel_i,
   input  logic        wr_en_i,
   input  logic [1:0]  address_in_i,
   input  logic [31:0] data_in_i,
   output logic [31:0] data_out_o,
   output logic        cmd_axis_tvalid_o,
   input  logic        cmd_axis_tready_i,
   output logic [31:0] cmd_axis_tdata_o
);
   localparam int AW = $clog2(DEPTH);
   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr, rd_ptr_n, wr_ptr_n;
   logic [LW-1:0] level, level_n;
   logic          overflow, full, empty, wr, rd, data_wr, flush, clr_ovf, push, pop, drop, bypass;
   logic [31:0]   status, rd_data, tdata_n, drops;
   assign wr      = sel_i && wr_en_i;
   assign rd      = sel_i && !wr_en_i;
   assign full    = level == LW'(DEPTH);
   assign empty   = level == '0;
   assign data_wr = wr && address_in_i == 2'd0;
   assign flush   = wr && address_in_i == 2'd1 && data_in_i[0];
   assign clr_ovf = wr && address_in_i == 2'd1 && data_in_i[1];
   assign push    = data_wr && !full && !flush;
   assign drop    = data_wr && full && !flush;
   assign pop     = cmd_axis_tvalid_o && cmd_axis_tready_i && !flush;
   assign level_n  = flush ? '0 : level + LW'(push) - LW'(pop);
   assign rd_ptr_n = flush ? '0 : rd_ptr + AW'(pop);
   assign wr_ptr_n = flush ? '0 : wr_ptr + AW'(push);
   // A push into an otherwise empty queue goes straight to the output register.
   assign bypass  = push && (level - LW'(pop)) == '0;
   assign tdata_n = bypass ? data_in_i : level_n != '0 ? mem[rd_ptr_n] : cmd_axis_tdata_o;
   always_comb begin
      status         = '0;
      status[LW-1:0] = level;
      status[16]     = empty;
      status[17]     = full;
      status[18]     = overflow;
      rd_data        = address_in_i == 2'd1 ? status : address_in_i == 2'd2 ? drops : '0;
   end
`ifdef VGA_CMD_FIFO_DROPS_EN
   always_ff @(posedge clk or negedge reset_n_i)
      if (!reset_n_i)
         drops <= '0;
      else if (wr && address_in_i == 2'd2)
         drops <= '0;
      else if (drop && drops != '1)
         drops <= drops + 32'd1;
`else
   assign drops = '0;
`endif
   always_ff @(posedge clk)
      if (push)
         mem[wr_ptr] <= data_in_i;
   always_ff @(posedge clk or negedge reset_n_i)
      if (!reset_n_i) begin
         rd_ptr            <= '0;
         wr_ptr            <= '0;
         level             <= '0;
         overflow          <= 1'b0;
         cmd_axis_tvalid_o <= 1'b0;
         cmd_axis_tdata_o  <= '0;
         data_out_o        <= '0;
      end else begin
         rd_ptr            <= rd_ptr_n;
         wr_ptr            <= wr_ptr_n;
         level             <= level_n;
         overflow          <= drop || (overflow && !clr_ovf);
         cmd_axis_tvalid_o <= level_n != '0;
         cmd_axis_tdata_o  <= tdata_n;
         if (rd)
            data_out_o <= rd_data;
      end
endmodule

// File: tb/tb_vga_cmd_fifo.sv
// tb_vga_cmd_fifo: directed vector table plus hand sequences for vga_cmd_fifo (DEPTH=16).
module tb_vga_cmd_fifo;
   logic        clk = 1'b0;
   logic        reset_n_i;
   logic        sel_i, wr_en_i, cmd_axis_tready_i;
   logic [1:0]  address_in_i;
   logic [31:0] data_in_i, data_out_o, cmd_axis_tdata_o;
   logic        cmd_axis_tvalid_o;
   int          ncmp = 0;
   int          nerr = 0;

   vga_cmd_fifo dut (
      .clk(clk), .reset_n_i(reset_n_i), .sel_i(sel_i), .wr_en_i(wr_en_i),
      .address_in_i(address_in_i), .data_in_i(data_in_i), .data_out_o(data_out_o),
      .cmd_axis_tvalid_o(cmd_axis_tvalid_o), .cmd_axis_tready_i(cmd_axis_tready_i),
      .cmd_axis_tdata_o(cmd_axis_tdata_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        sel, we;
      logic [1:0]  a;
      logic [31:0] d;
      logic        rdy, vld;
      logic [31:0] td, dout;
   } vec_t;

   function automatic vec_t v(input logic sel, we, input logic [1:0] a, input logic [31:0] d,
                              input logic rdy, vld, input logic [31:0] td, dout);
      v = {sel, we, a, d, rdy, vld, td, dout};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step(input logic s, we, input logic [1:0] a, input logic [31:0] d, input logic r);
      sel_i = s; wr_en_i = we; address_in_i = a; data_in_i = d; cmd_axis_tready_i = r;
      @(posedge clk);
      #1;
   endtask

   task automatic wr_data(input logic [31:0] d);
      step(1, 1, 2'd0, d, 0);
   endtask

   task automatic rd_reg(input logic [1:0] a);
      step(1, 0, a, 32'h0, 0);
   endtask

   vec_t tv [19];
   logic [31:0] q [$];
   logic [31:0] exp_drops;

   initial begin
`ifdef VGA_CMD_FIFO_DROPS_EN
      exp_drops = 32'd1;
`else
      exp_drops = 32'd0;
`endif
      tv[0]  = v(1, 0, 1, 0,            0, 0, 32'h0,        32'h10000);
      tv[1]  = v(1, 1, 0, 32'hA5A50001, 0, 1, 32'hA5A50001, 32'h10000);
      tv[2]  = v(0, 0, 0, 0,            0, 1, 32'hA5A50001, 32'h10000);
      tv[3]  = v(1, 0, 1, 0,            0, 1, 32'hA5A50001, 32'h1);
      tv[4]  = v(1, 1, 0, 32'h11,       0, 1, 32'hA5A50001, 32'h1);
      tv[5]  = v(1, 0, 1, 0,            0, 1, 32'hA5A50001, 32'h2);
      tv[6]  = v(0, 0, 0, 0,            1, 1, 32'h11,       32'h2);
      tv[7]  = v(1, 0, 1, 0,            0, 1, 32'h11,       32'h1);
      tv[8]  = v(0, 0, 0, 0,            1, 0, 32'h11,       32'h1);
      tv[9]  = v(1, 0, 1, 0,            0, 0, 32'h11,       32'h10000);
      tv[10] = v(1, 0, 0, 0,            0, 0, 32'h11,       32'h0);
      tv[11] = v(1, 0, 1, 0,            0, 0, 32'h11,       32'h10000);
      tv[12] = v(1, 0, 3, 0,            0, 0, 32'h11,       32'h0);
      tv[13] = v(1, 1, 0, 32'h22,       1, 1, 32'h22,       32'h0);
      tv[14] = v(1, 1, 0, 32'h33,       1, 1, 32'h33,       32'h0);
      tv[15] = v(1, 1, 1, 32'h1,        0, 0, 32'h33,       32'h0);
      tv[16] = v(1, 0, 1, 0,            0, 0, 32'h33,       32'h10000);
      tv[17] = v(1, 1, 2, 0,            0, 0, 32'h33,       32'h10000);
      tv[18] = v(1, 0, 2, 0,            0, 0, 32'h33,       32'h0);

      reset_n_i = 1'b0;
      sel_i = 0; wr_en_i = 0; address_in_i = 0; data_in_i = 0; cmd_axis_tready_i = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n_i = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_tvalid", {31'b0, cmd_axis_tvalid_o}, 32'h0);
      chk("rst_tdata", cmd_axis_tdata_o, 32'h0);
      chk("rst_dout", data_out_o, 32'h0);

      for (int i = 0; i < 19; i++) begin
         step(tv[i].sel, tv[i].we, tv[i].a, tv[i].d, tv[i].rdy);
         chk($sformatf("vec%0d_tvalid", i), {31'b0, cmd_axis_tvalid_o}, {31'b0, tv[i].vld});
         chk($sformatf("vec%0d_tdata", i), cmd_axis_tdata_o, tv[i].td);
         chk($sformatf("vec%0d_dout", i), data_out_o, tv[i].dout);
      end
      step(1, 1, 2'd1, 32'h1, 0);

      // asynchronous reset mid-cycle with a command queued
      wr_data(32'hDEAD0001);
      rd_reg(2'd1);
      step(0, 0, 0, 0, 0);
      #3 reset_n_i = 1'b0;
      #1;
      chk("async_tvalid", {31'b0, cmd_axis_tvalid_o}, 32'h0);
      chk("async_tdata", cmd_axis_tdata_o, 32'h0);
      chk("async_dout", data_out_o, 32'h0);
      @(negedge clk);
      reset_n_i = 1'b1;
      rd_reg(2'd1);
      chk("async_status", data_out_o, 32'h10000);

      // single command held stable under back-pressure
      wr_data(32'hA5A50001);
      for (int i = 0; i < 10; i++) begin
         chk("hold_tvalid", {31'b0, cmd_axis_tvalid_o}, 32'h1);
         chk("hold_tdata", cmd_axis_tdata_o, 32'hA5A50001);
         step(0, 0, 0, 0, 0);
      end
      step(0, 0, 0, 0, 1);
      chk("hold_pop_tvalid", {31'b0, cmd_axis_tvalid_o}, 32'h0);
      rd_reg(2'd1);
      chk("hold_status", data_out_o, 32'h10000);

      // fill past full, then drain without bubbles
      for (int i = 0; i <= 16; i++) wr_data(i);
      rd_reg(2'd1);
      chk("fill_status", data_out_o, 32'h00060010);
      rd_reg(2'd2);
      chk("fill_drops", data_out_o, exp_drops);
      for (int i = 0; i < 16; i++) begin
         chk("drain_tvalid", {31'b0, cmd_axis_tvalid_o}, 32'h1);
         chk("drain_tdata", cmd_axis_tdata_o, i);
         step(0, 0, 0, 0, 1);
      end
      chk("drain_empty", {31'b0, cmd_axis_tvalid_o}, 32'h0);
      rd_reg(2'd1);
      chk("drain_status", data_out_o, 32'h00050000);
      step(1, 1, 2'd1, 32'h2, 0);
      rd_reg(2'd1);
      chk("clr_ovf_status", data_out_o, 32'h00010000);

      // simultaneous push and pop at level 3
      for (int i = 0; i < 3; i++) wr_data(32'h100 + i);
      step(1, 1, 2'd0, 32'h103, 1);
      rd_reg(2'd1);
      chk("pp_level", data_out_o, 32'h3);
      for (int k = 1; k <= 3; k++) begin
         chk("pp_order", cmd_axis_tdata_o, 32'h100 + k);
         step(0, 0, 0, 0, 1);
      end
      chk("pp_empty", {31'b0, cmd_axis_tvalid_o}, 32'h0);

      // push while full with a simultaneous pop is still dropped
      for (int i = 0; i < 16; i++) wr_data(32'h200 + i);
      step(1, 1, 2'd0, 32'h999, 1);
      chk("fullpp_tdata", cmd_axis_tdata_o, 32'h201);
      rd_reg(2'd1);
      chk("fullpp_status", data_out_o, 32'h0004000F);
      step(1, 1, 2'd1, 32'h3, 0);
      rd_reg(2'd1);
      chk("flushclr_status", data_out_o, 32'h00010000);

      // flush during stall
      for (int i = 0; i < 5; i++) wr_data(32'h300 + i);
      step(1, 1, 2'd1, 32'h1, 0);
      chk("flush_tvalid", {31'b0, cmd_axis_tvalid_o}, 32'h0);
      rd_reg(2'd1);
      chk("flush_status", data_out_o, 32'h00010000);
      wr_data(32'h77);
      chk("postflush_tvalid", {31'b0, cmd_axis_tvalid_o}, 32'h1);
      chk("postflush_tdata", cmd_axis_tdata_o, 32'h77);
      rd_reg(2'd1);
      chk("postflush_status", data_out_o, 32'h1);
      step(1, 1, 2'd1, 32'h1, 0);

      // random stream across pointer wrap with random back-pressure
      begin
         int sent, got;
         logic p, r;
         logic [31:0] w;
         sent = 0;
         got = 0;
         for (int cyc = 0; cyc < 3000 && got < 100; cyc++) begin
            p = sent < 100 && q.size() < 16 && $urandom_range(0, 3) != 0;
            r = 1'($urandom_range(0, 1));
            w = $urandom;
            chk("rnd_tvalid", {31'b0, cmd_axis_tvalid_o}, {31'b0, q.size() != 0});
            if (r && q.size() != 0) begin
               chk("rnd_tdata", cmd_axis_tdata_o, q.pop_front());
               got++;
            end
            if (p) begin
               q.push_back(w);
               sent++;
            end
            step(p, 1, 2'd0, w, r);
         end
         chk("rnd_count", got, 100);
         rd_reg(2'd1);
         chk("rnd_status", data_out_o, 32'h00010000);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end
endmodule
